// File: rtl/au_pkg.sv
// Shared definitions for the aggregation-unit (AU) gather sequencer.
//   - au_state_e     : sequencer FSM states
//   - *_DEF          : default widths / neighbour count
//   - au_field_lsb() : bit offset of a field inside an NIT row
//                      (field 0 = centroid, field k+1 = neighbour k)
package au_pkg;

  localparam int unsigned NIT_ADDR_WIDTH_DEF  = 8;
  localparam int unsigned NIT_NEIGHBOR_DEF    = 16;
  localparam int unsigned NIT_POINT_INDEX_DEF = 10;
  localparam int unsigned PFT_ADDR_WIDTH_DEF  = 10;
  localparam int unsigned PFT_LAT_DEF         = 1;
  localparam int unsigned SUB_LAT_DEF         = 1;

  typedef enum logic [2:0] {
    StIdle,
    StNitRd,
    StLatch,
    StCent,
    StNbr,
    StDrain
  } au_state_e;

  function automatic int unsigned au_field_lsb(input int unsigned field,
                                               input int unsigned point_w);
    return field * point_w;
  endfunction

endpackage

// File: rtl/au_delay_pipe.sv
// Fixed-depth shift register with synchronous active-high reset.
// Ports:
//   clk_i : clock
//   rst_i : synchronous reset, clears every stage
//   d_i   : input word
//   q_o   : input word delayed by Depth cycles (Depth >= 1)
module au_delay_pipe #(
  parameter int unsigned Depth = 1,
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] pipe_q [Depth];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(Depth); i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= d_i;
      for (int i = 1; i < int'(Depth); i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign q_o = pipe_q[Depth-1];

endmodule

// File: rtl/nit_gather_ctrl.sv
// Gather sequencer for the aggregation unit. Walks the neighbour index table
// row by row, issues PFT reads (centroid, then every neighbour) and produces
// time-aligned enables for the subtract stage and first/valid flags for the
// max stage, plus a per-group "result final" strobe.
//
// Optional build macro NIT_PREFETCH_EN: the next NIT row is read during the
// tail of the current neighbour burst into a shadow register so the FSM can
// go NBR -> CENT directly (1+N cycles per group instead of 3+N).
//
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   start          : pass start pulse (ignored while busy)
//   num_centroid   : rows to process, sampled on start
//   nit_addr       : NIT row address, nit_dout returns it one cycle later
//   pft_addr       : PFT read address, pft_valid marks an issued read
//   is_centroid    : current PFT read is the centroid of the row
//   en_centroid    : subtract stage latches centroid (PFT data cycle)
//   en_neighbor    : subtract stage neighbour data valid (PFT data cycle)
//   max_first      : max stage restarts with din
//   max_valid      : max stage din valid
//   grp_valid      : max output holds the final result of group grp_idx
//   busy, done     : pass in progress, one-cycle end-of-pass pulse
module nit_gather_ctrl
  import au_pkg::*;
#(
  parameter int unsigned NIT_addr_width  = NIT_ADDR_WIDTH_DEF,
  parameter int unsigned NIT_neighbor    = NIT_NEIGHBOR_DEF,
  parameter int unsigned NIT_point_index = NIT_POINT_INDEX_DEF,
  parameter int unsigned PFT_addr_width  = PFT_ADDR_WIDTH_DEF,
  parameter int unsigned PFT_LAT         = PFT_LAT_DEF,
  parameter int unsigned SUB_LAT         = SUB_LAT_DEF
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        start,
  input  logic [NIT_addr_width:0]                     num_centroid,
  output logic [NIT_addr_width-1:0]                   nit_addr,
  input  logic [(NIT_neighbor+1)*NIT_point_index-1:0] nit_dout,
  output logic [PFT_addr_width-1:0]                   pft_addr,
  output logic                                        pft_valid,
  output logic                                        is_centroid,
  output logic                                        en_centroid,
  output logic                                        en_neighbor,
  output logic                                        max_first,
  output logic                                        max_valid,
  output logic                                        grp_valid,
  output logic [NIT_addr_width-1:0]                   grp_idx,
  output logic                                        busy,
  output logic                                        done
);

  localparam int unsigned RowW  = (NIT_neighbor + 1) * NIT_point_index;
  localparam int unsigned KW    = $clog2(NIT_neighbor);
  localparam int unsigned A     = NIT_addr_width;
  localparam logic [KW-1:0] KLast = KW'(NIT_neighbor - 1);
`ifdef NIT_PREFETCH_EN
  localparam logic [KW-1:0] KPre  = KW'(NIT_neighbor - 2);
`endif

  au_state_e       state_q, state_d;
  logic [A-1:0]    row_q, row_d;
  logic [KW-1:0]   k_q, k_d;
  logic [A:0]      num_q, num_d;
  logic [RowW-1:0] row_data_q, row_data_d;
  logic            done_q, done_d;
`ifdef NIT_PREFETCH_EN
  logic [RowW-1:0] shadow_q, shadow_d;
`endif

  logic                       more_rows;
  logic [NIT_point_index-1:0] cent_idx;
  logic [NIT_point_index-1:0] nbr_idx;

  assign more_rows = ({1'b0, row_q} + {{A{1'b0}}, 1'b1}) < num_q;

`ifdef NIT_PREFETCH_EN
  // Centroid is read straight from the shadow so a prefetched row can be used
  // the cycle after it is captured; CENT then copies it into the row register.
  assign cent_idx = shadow_q[au_field_lsb(0, NIT_point_index) +: NIT_point_index];
`else
  assign cent_idx = row_data_q[au_field_lsb(0, NIT_point_index) +: NIT_point_index];
`endif
  assign nbr_idx = row_data_q[au_field_lsb(32'(k_q) + 1, NIT_point_index) +: NIT_point_index];

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    k_d         = k_q;
    num_d       = num_q;
    row_data_d  = row_data_q;
    done_d      = 1'b0;
`ifdef NIT_PREFETCH_EN
    shadow_d    = shadow_q;
`endif
    nit_addr    = '0;
    pft_addr    = '0;
    pft_valid   = 1'b0;
    is_centroid = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (num_centroid == '0) begin
            done_d = 1'b1;
          end else begin
            num_d   = num_centroid;
            row_d   = '0;
            state_d = StNitRd;
          end
        end
      end
      StNitRd: begin
        nit_addr = row_q;
        state_d  = StLatch;
      end
      StLatch: begin
`ifdef NIT_PREFETCH_EN
        shadow_d   = nit_dout;
`else
        row_data_d = nit_dout;
`endif
        state_d = StCent;
      end
      StCent: begin
        pft_addr    = PFT_addr_width'(cent_idx);
        pft_valid   = 1'b1;
        is_centroid = 1'b1;
        k_d         = '0;
`ifdef NIT_PREFETCH_EN
        row_data_d  = shadow_q;
`endif
        state_d     = StNbr;
      end
      StNbr: begin
        pft_addr  = PFT_addr_width'(nbr_idx);
        pft_valid = 1'b1;
        k_d       = k_q + 1'b1;
`ifdef NIT_PREFETCH_EN
        // Next row read overlaps the last two neighbour reads; never past the last row.
        if (more_rows && (k_q == KPre)) begin
          nit_addr = row_q + 1'b1;
        end
        if (more_rows && (k_q == KLast)) begin
          shadow_d = nit_dout;
        end
`endif
        if (k_q == KLast) begin
          k_d = '0;
          if (more_rows) begin
            row_d = row_q + 1'b1;
`ifdef NIT_PREFETCH_EN
            state_d = StCent;
`else
            state_d = StNitRd;
`endif
          end else begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        // Only the last group is still in flight here.
        if (grp_valid) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      row_q      <= '0;
      k_q        <= '0;
      num_q      <= '0;
      row_data_q <= '0;
      done_q     <= 1'b0;
`ifdef NIT_PREFETCH_EN
      shadow_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      k_q        <= k_d;
      num_q      <= num_d;
      row_data_q <= row_data_d;
      done_q     <= done_d;
`ifdef NIT_PREFETCH_EN
      shadow_q   <= shadow_d;
`endif
    end
  end

  assign busy = (state_q != StIdle);
  assign done = done_q;

  // Per-read tags that travel alongside the data through the PFT and subtract
  // latencies so the downstream flags line up with their own data.
  logic         nbr_rd;
  logic         tag_first, tag_last;
  logic [A-1:0] tag_row;
  logic         s1_first, s1_last;
  logic [A-1:0] s1_row;
  logic         s2_first, s2_last;
  logic [A-1:0] s2_row;
  logic         grp_fire;
  logic [A-1:0] grp_row;

  assign nbr_rd    = pft_valid & ~is_centroid;
  assign tag_first = nbr_rd & (k_q == '0);
  assign tag_last  = nbr_rd & (k_q == KLast);
  assign tag_row   = nbr_rd ? row_q : '0;

  au_delay_pipe #(
    .Depth (PFT_LAT),
    .Width (4 + A)
  ) u_pft_pipe (
    .clk_i (clk),
    .rst_i (rst),
    .d_i   ({is_centroid, nbr_rd, tag_first, tag_last, tag_row}),
    .q_o   ({en_centroid, en_neighbor, s1_first, s1_last, s1_row})
  );

  au_delay_pipe #(
    .Depth (SUB_LAT),
    .Width (3 + A)
  ) u_sub_pipe (
    .clk_i (clk),
    .rst_i (rst),
    .d_i   ({en_neighbor, s1_first, s1_last, s1_row}),
    .q_o   ({max_valid, s2_first, s2_last, s2_row})
  );

  assign max_first = max_valid & s2_first;
  assign grp_fire  = max_valid & s2_last;
  assign grp_row   = grp_fire ? s2_row : '0;

  // One extra stage for the max register itself.
  au_delay_pipe #(
    .Depth (1),
    .Width (1 + A)
  ) u_grp_pipe (
    .clk_i (clk),
    .rst_i (rst),
    .d_i   ({grp_fire, grp_row}),
    .q_o   ({grp_valid, grp_idx})
  );

endmodule

// File: tb/tb_nit_gather_ctrl.sv
module tb_nit_gather_ctrl;

  localparam int A    = 8;
  localparam int N    = 16;
  localparam int P    = 10;
  localparam int PW   = 10;
  localparam int RowW = (N + 1) * P;
`ifdef NIT_PREFETCH_EN
  localparam int Spacing = N + 1;
`else
  localparam int Spacing = N + 3;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [A:0]      num_centroid;
  logic [A-1:0]    nit_addr;
  logic [RowW-1:0] nit_dout;
  logic [PW-1:0]   pft_addr;
  logic            pft_valid, is_centroid, en_centroid, en_neighbor;
  logic            max_first, max_valid, grp_valid, busy, done;
  logic [A-1:0]    grp_idx;

  nit_gather_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .num_centroid (num_centroid),
    .nit_addr     (nit_addr),
    .nit_dout     (nit_dout),
    .pft_addr     (pft_addr),
    .pft_valid    (pft_valid),
    .is_centroid  (is_centroid),
    .en_centroid  (en_centroid),
    .en_neighbor  (en_neighbor),
    .max_first    (max_first),
    .max_valid    (max_valid),
    .grp_valid    (grp_valid),
    .grp_idx      (grp_idx),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  // NIT memory: one-cycle read latency.
  logic [RowW-1:0] nit_mem [3];
  always @(posedge clk) nit_dout <= (nit_addr < 3) ? nit_mem[nit_addr[1:0]] : '0;

  function automatic int pft_f(input int a);
    return (a * 37 + 11) % 256;
  endfunction

  // PFT -> subtract -> max reference datapath, each stage one cycle.
  int pft_dout, cent_v, sub_v, max_v;
  always @(posedge clk) begin
    pft_dout <= pft_f(int'(pft_addr));
    if (en_centroid) cent_v <= pft_dout;
    if (en_neighbor) sub_v <= pft_dout - cent_v;
    if (max_valid) max_v <= max_first ? sub_v : ((sub_v > max_v) ? sub_v : max_v);
  end

  function automatic int golden(input int r);
    int c, best, d;
    c    = pft_f(int'(nit_mem[r][P-1:0]));
    best = -100000;
    for (int k = 0; k < N; k++) begin
      d = pft_f(int'(nit_mem[r][(k+1)*P +: P])) - c;
      if (d > best) best = d;
    end
    return best;
  endfunction

  task automatic set_row(input int r, input int c, input int base, input int step);
    nit_mem[r][P-1:0] = P'(c);
    for (int k = 0; k < N; k++) nit_mem[r][(k+1)*P +: P] = P'(base + k * step);
  endtask

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Event log of the current pass, cycles relative to the start cycle.
  int rel;
  int pft_q[$];
  int grp_cyc[$], grp_id[$], grp_max[$];
  int pft_first, pft_last, ec_first, mf_first, mf_cnt;
  int done_cnt, done_rel, busy_seen, busy_last, nit_at1;
  int ref_pft[$], ref_grp[$];

  task automatic clear_log();
    pft_q.delete(); grp_cyc.delete(); grp_id.delete(); grp_max.delete();
    pft_first = -1; pft_last = -1; ec_first = -1; mf_first = -1; mf_cnt = 0;
    done_cnt = 0; done_rel = -1; busy_seen = 0; busy_last = -1; nit_at1 = -1;
  endtask

  task automatic tick();
    @(negedge clk);
    rel++;
    if (pft_valid) begin
      pft_q.push_back(int'(pft_addr));
      if (pft_first < 0) pft_first = rel;
      pft_last = rel;
    end
    if (en_centroid && ec_first < 0) ec_first = rel;
    if (max_first) begin
      mf_cnt++;
      if (mf_first < 0) mf_first = rel;
    end
    if (grp_valid) begin
      grp_cyc.push_back(rel);
      grp_id.push_back(int'(grp_idx));
      grp_max.push_back(max_v);
    end
    if (done) begin
      done_cnt++;
      done_rel = rel;
    end
    if (busy) begin
      busy_seen++;
      busy_last = rel;
    end
    if (rel == 1) nit_at1 = int'(nit_addr);
  endtask

  // Called at a negedge: start is high for cycle 0.
  task automatic start_pass(input int num);
    clear_log();
    rel          = 0;
    start        = 1'b1;
    num_centroid = (A+1)'(num);
    tick();
    start = 1'b0;
  endtask

  int errs;
  int sevens;
  logic [63:0] outs;

  initial begin
    set_row(0, 5, 10, 1);
    set_row(1, 100, 300, 7);
    set_row(2, 7, 7, 0);
    rst = 1'b1; start = 1'b0; num_centroid = '0;
    clear_log();
    rel = 0;
    repeat (3) tick();
    outs = 64'({nit_addr, pft_addr, pft_valid, is_centroid, en_centroid, en_neighbor,
                max_first, max_valid, grp_valid, grp_idx, busy, done});
    check("reset_outputs", int'(outs[31:0]) | int'(outs[63:32]), 0);
    rst = 1'b0;
    tick();

    // Single group.
    start_pass(1);
    repeat (29) tick();
    check("g1_nit_addr_c1", nit_at1, 0);
    check("g1_pft_count", pft_q.size(), 17);
    check("g1_pft_first_cyc", pft_first, 3);
    check("g1_pft_last_cyc", pft_last, 19);
    errs = 0;
    for (int i = 0; i < 17; i++) if (pft_q[i] != ((i == 0) ? 5 : 9 + i)) errs++;
    check("g1_pft_addr_seq_errs", errs, 0);
    check("g1_en_centroid_cyc", ec_first, 4);
    check("g1_max_first_cyc", mf_first, 6);
    check("g1_grp_count", grp_cyc.size(), 1);
    check("g1_grp_cyc", grp_cyc[0], 22);
    check("g1_grp_idx", grp_id[0], 0);
    check("g1_grp_max", grp_max[0], golden(0));
    check("g1_done_cyc", done_rel, 23);
    check("g1_done_count", done_cnt, 1);
    check("g1_busy_last", busy_last, 22);

    // Three groups; row 2 has every neighbour equal to its centroid.
    start_pass(3);
    repeat (79) tick();
    check("g3_grp_count", grp_cyc.size(), 3);
    for (int g = 0; g < 3; g++) begin
      check("g3_grp_cyc", grp_cyc[g], 22 + g * Spacing);
      check("g3_grp_idx", grp_id[g], g);
      check("g3_grp_max", grp_max[g], golden(g));
    end
    check("g3_done_cyc", done_rel, 23 + 2 * Spacing);
    check("g3_done_count", done_cnt, 1);
    check("g3_pft_count", pft_q.size(), 51);
    check("g3_row1_centroid", pft_q[17], 100);
    sevens = 0;
    for (int i = 34; i < 51; i++) if (pft_q[i] == 7) sevens++;
    check("dup_reads_of_7", sevens, 17);
    check("dup_max_first_per_grp", mf_cnt, 3);
    ref_pft = pft_q;
    ref_grp = grp_cyc;

    // Same pass with start re-pulsed and num_centroid changed mid-pass.
    start_pass(3);
    for (int i = 1; i < 80; i++) begin
      start = (rel == 10) || (rel == 45);
      if (rel == 10) num_centroid = 1;
      if (rel == 30) num_centroid = 5;
      tick();
    end
    start = 1'b0;
    num_centroid = '0;
    check("dist_grp_count", grp_cyc.size(), ref_grp.size());
    errs = 0;
    for (int i = 0; i < ref_grp.size(); i++) if (grp_cyc[i] != ref_grp[i]) errs++;
    check("dist_grp_cyc_errs", errs, 0);
    check("dist_pft_count", pft_q.size(), ref_pft.size());
    errs = 0;
    for (int i = 0; i < ref_pft.size(); i++) if (pft_q[i] != ref_pft[i]) errs++;
    check("dist_pft_addr_errs", errs, 0);
    check("dist_done_count", done_cnt, 1);

    // Empty pass.
    start_pass(0);
    repeat (5) tick();
    check("zero_done_cyc", done_rel, 1);
    check("zero_done_count", done_cnt, 1);
    check("zero_pft_reads", pft_q.size(), 0);
    check("zero_busy_cycles", busy_seen, 0);

    // Reset in the neighbour burst of group 1.
    start_pass(3);
    repeat (27) tick();
    rst = 1'b1;
    tick();
    outs = 64'({nit_addr, pft_addr, pft_valid, is_centroid, en_centroid, en_neighbor,
                max_first, max_valid, grp_valid, grp_idx, busy, done});
    check("rst_mid_outputs", int'(outs[31:0]) | int'(outs[63:32]), 0);
    rst = 1'b0;
    clear_log();
    repeat (60) tick();
    check("rst_no_grp_after", grp_cyc.size(), 0);
    check("rst_no_done_after", done_cnt, 0);
    check("rst_no_reads_after", pft_q.size(), 0);
    start_pass(1);
    repeat (29) tick();
    check("rst_restart_first_addr", pft_q[0], 5);
    check("rst_restart_grp_cyc", grp_cyc[0], 22);
    check("rst_restart_grp_idx", grp_id[0], 0);
    check("rst_restart_done_cyc", done_rel, 23);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nit_gather_ctrl.md
Name: nit_gather_ctrl

Overview:
Sequencer for the aggregation unit (AU), sitting directly upstream of the PFT → subtract_module32 → max_module32 datapath.
- Walks the neighbour index table (NIT) row by row.
- Drives PFT read addresses: centroid first, then each neighbour.
- Generates time-aligned enables for the subtract stage and the first/valid flags for the max stage.
- Marks when each group's max-pooled feature is final.

Parameters:
NIT_addr_width, 8, NIT row address width (max centroids = 2^NIT_addr_width)
NIT_neighbor, 16, neighbours per NIT row (>= 2)
NIT_point_index, 10, bit width of one point index
PFT_addr_width, 10, PFT address width (>= NIT_point_index; index zero-extended)
PFT_LAT, 1, PFT read latency in cycles
SUB_LAT, 1, subtract_module32 latency in cycles

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse, begins a pass; ignored while busy
num_centroid  in  NIT_addr_width+1  rows to process, sampled on start
nit_addr  out  NIT_addr_width  NIT row address
nit_dout  in  (NIT_neighbor+1)*NIT_point_index  NIT row, valid 1 cycle after nit_addr
pft_addr  out  PFT_addr_width  PFT read address
pft_valid  out  1  PFT read issued this cycle
is_centroid  out  1  current PFT read is the centroid
en_centroid  out  1  subtract stage: latch centroid (PFT dout cycle)
en_neighbor  out  1  subtract stage: neighbour input valid (PFT dout cycle)
max_first  out  1  max stage: take din, ignore previous_data
max_valid  out  1  max stage: din valid
grp_valid  out  1  max dout holds final group result
grp_idx  out  NIT_addr_width  row index belonging to grp_valid
busy  out  1  pass in progress
done  out  1  one-cycle pulse at end of pass

Behaviour:
- Reset: all outputs 0, FSM = IDLE, counters 0, delay pipes cleared. Applies immediately mid-pass; no partial grp_valid or done afterwards.
- Row layout: centroid index at bits [P-1:0]; neighbour k at [(k+1)*P +: P], k = 0..N-1 (P = NIT_point_index, N = NIT_neighbor).
- FSM states:
  - IDLE: on start with num_centroid = 0, pulse done next cycle, no reads. On start otherwise, row ← 0, busy ← 1, go to NIT_RD.
  - NIT_RD: nit_addr = row, one cycle → LATCH.
  - LATCH: capture nit_dout into row register → CENT.
  - CENT: pft_addr = centroid index, pft_valid = 1, is_centroid = 1 → NBR with k = 0.
  - NBR: pft_addr = neighbour k, pft_valid = 1; k increments each cycle. At k = N-1: row+1 < num_centroid → NIT_RD (row++); otherwise → DRAIN.
  - DRAIN: wait until the last grp_valid has fired, then pulse done, clear busy → IDLE.
- Timing alignment via shift-register delay pipes:
  - en_centroid / en_neighbor = is_centroid / (pft_valid & !is_centroid), delayed PFT_LAT.
  - max_valid = en_neighbor delayed SUB_LAT.
  - max_first = max_valid restricted to neighbour k = 0.
  - grp_valid = max_valid of neighbour k = N-1, delayed 1 (max register).
  - grp_idx travels with its group through the same pipes.
- Defaults: last neighbour issued at cycle t → grp_valid at t+3, done at t+4.
- Throughput without prefetch: 3+N cycles per group.
- start while busy: ignored. num_centroid is latched, so later changes have no effect on the running pass.

Optional Feature:
NIT_PREFETCH_EN
- Defined:
  - Next row's nit_addr is issued in NBR at k = N-2.
  - nit_dout is captured into a shadow register at k = N-1.
  - FSM goes NBR → CENT directly, giving 1+N cycles per group.
  - The first row still uses NIT_RD/LATCH.
  - No prefetch read is issued after the last row.
- Undefined: behaviour exactly as above, no shadow register.

Decomposition:
- Shared package au_pkg holds:
  - FSM state enum (IDLE, NIT_RD, LATCH, CENT, NBR, DRAIN).
  - Default widths and NIT_neighbor.
  - Row-field extraction helper function.
- One natural sub-module: au_delay_pipe, a parameterised-depth, parameterised-width shift register with synchronous reset. It is instantiated for the enable, flag and grp_idx pipes.

Test Plan:
- Single group: num_centroid=1, NIT row0 = centroid 5, neighbours 10..25, start at cycle 0.
  - nit_addr=0 @1; pft_addr 5,10,11..25 @3..19; en_centroid @4; max_first @6; grp_valid, grp_idx=0 @22; done @23; busy low @23.
- Multi-group: num_centroid=3.
  - grp_valid exactly 3 pulses, grp_idx 0,1,2, spaced 19 cycles (no prefetch) / 17 cycles (NIT_PREFETCH_EN).
  - Bench max model output matches the golden per-group max.
- num_centroid=0 start: done pulses next cycle; pft_valid and nit_addr reads never asserted; busy stays 0.
- start re-pulsed mid-pass and num_centroid changed mid-pass: pass unaffected, same pulse count and addresses as an undisturbed run.
- rst asserted during NBR of group 1 of 3: the following cycle all outputs 0; no grp_valid/done appear later; a new start runs cleanly from row 0.
- Duplicate indices (all neighbours = centroid 7): 17 reads of address 7, max_first only once per group, grp_valid timing unchanged.
